// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, fetches 8-bit words from ROM,
// splits them into fields and hands them to decode via valid/ready.
module instruction_fetch_unit #(
   parameter int PC_WIDTH = 8,
   parameter int MAX_WAIT = 4
) (
   input  logic                input_Clock,
   input  logic                input_Reset_n,
   input  logic                input_Enable,
   output logic                output_MemReq,
   output logic [PC_WIDTH-1:0] output_MemAddr,
   input  logic                input_MemValid,
   input  logic [7:0]          input_MemData,
   output logic                output_InstrValid,
   input  logic                input_InstrReady,
   output logic [1:0]          output_Operator,
   output logic [1:0]          output_Rs,
   output logic [1:0]          output_Rt,
   output logic [1:0]          output_Rd,
   output logic [PC_WIDTH-1:0] output_Imm,
   output logic [PC_WIDTH-1:0] output_PC,
   input  logic                input_BranchDone,
   input  logic                input_BranchTaken,
   output logic                output_Fault,
   output logic [15:0]         output_InstrCount
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_ISSUE,
      S_BRANCH,
      S_FAULT
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);
   localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [7:0]          ir_q, ir_d;
   logic [3:0]          wait_q, wait_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [PC_WIDTH-1:0] imm;
   logic [PC_WIDTH-1:0] pc_next;

   assign imm     = {{(PC_WIDTH-2){ir_q[1]}}, ir_q[1:0]};
   assign pc_next = pc_q + PC_ONE;

   always_ff @(posedge input_Clock or negedge input_Reset_n) begin
      if (!input_Reset_n) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         wait_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      wait_d  = wait_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (input_Enable) state_d = S_FETCH;
         end
         S_FETCH: begin
            wait_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // a response on the last allowed cycle beats the timeout
            if (input_MemValid) begin
               ir_d    = input_MemData;
               state_d = S_ISSUE;
            end else begin
               wait_d = wait_q + 4'd1;
               if (wait_q + 4'd1 == WAIT_LAST) state_d = S_FAULT;
            end
         end
         S_ISSUE: begin
            if (input_InstrReady) begin
               cnt_d = cnt_q + 16'd1;
               if (ir_q[7:6] == 2'b11) begin
                  state_d = S_BRANCH;
               end else begin
                  pc_d    = pc_next;
                  state_d = input_Enable ? S_FETCH : S_IDLE;
               end
            end
         end
         S_BRANCH: begin
            if (input_BranchDone) begin
               pc_d    = input_BranchTaken ? pc_next + imm : pc_next;
               state_d = input_Enable ? S_FETCH : S_IDLE;
            end
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase
   end

   assign output_MemReq     = (state_q == S_FETCH);
   assign output_InstrValid = (state_q == S_ISSUE);
   assign output_Fault      = (state_q == S_FAULT);
   assign output_MemAddr    = pc_q;
   assign output_PC         = pc_q;
   assign output_Operator   = ir_q[7:6];
   assign output_Rs         = ir_q[5:4];
   assign output_Rt         = ir_q[3:2];
   assign output_Rd         = ir_q[1:0];
   assign output_Imm        = imm;
   assign output_InstrCount = cnt_q;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Feeds the control decoder: fetches 8-bit instructions from instruction ROM, splits them into opcode and fields, and presents them with a valid/ready handshake.
- Owns the program counter (PC): sequential increment, plus redirect for branch opcode 2'b11 once the datapath resolves the branch.
- Sits between instruction memory and the decode/control stage. Detects memory-response timeouts.

Parameters:
- PC_WIDTH, 8, width of PC and memory address; all PC arithmetic is modulo 2^PC_WIDTH.
- MAX_WAIT, 4, maximum cycles WAIT may last without input_MemValid before a fault; legal range 2..15.

Ports:
- input_Clock, in, 1, single clock; everything updates on the rising edge.
- input_Reset_n, in, 1, asynchronous active-low reset.
- input_Enable, in, 1, run request; sampled only in IDLE and at instruction retirement.
- output_MemReq, out, 1, one-cycle fetch request.
- output_MemAddr, out, PC_WIDTH, fetch address (equals PC).
- input_MemValid, in, 1, memory data valid strobe.
- input_MemData, in, 8, instruction word.
- output_InstrValid, out, 1, decoded instruction valid.
- input_InstrReady, in, 1, decode stage accepts the instruction.
- output_Operator, out, 2, instr[7:6].
- output_Rs, out, 2, instr[5:4].
- output_Rt, out, 2, instr[3:2].
- output_Rd, out, 2, instr[1:0].
- output_Imm, out, PC_WIDTH, sign-extended instr[1:0].
- output_PC, out, PC_WIDTH, PC of the presented instruction.
- input_BranchDone, in, 1, branch resolution strobe.
- input_BranchTaken, in, 1, branch outcome; valid only with input_BranchDone.
- output_Fault, out, 1, sticky memory-timeout flag.
- output_InstrCount, out, 16, count of accepted instructions; wraps at 65535 to 0.

Behaviour:
- Reset (async, input_Reset_n=0):
  - State goes to IDLE.
  - PC, the instruction register, the wait counter and InstrCount all clear to 0.
  - Every output reads 0, including output_Fault.
- Outputs:
  - output_MemReq, output_InstrValid and output_Fault are decoded from state only (Moore).
  - The field outputs come from the registered instruction; they hold stable while output_InstrValid=1.
- IDLE: if input_Enable=1, go to FETCH next cycle.
- FETCH:
  - output_MemReq=1 and output_MemAddr=PC for exactly one cycle; wait counter clears.
  - Always go to WAIT.
  - input_MemValid during FETCH is ignored (memory latency is at least 1 cycle).
- WAIT:
  - If input_MemValid=1: latch input_MemData, go to ISSUE.
  - Otherwise increment the wait counter; when it reaches MAX_WAIT-1 with no valid, go to FAULT.
  - A response on wait cycle MAX_WAIT-1 is still accepted; valid has priority over the timeout.
- ISSUE:
  - output_InstrValid=1; hold until input_InstrReady=1.
  - On the handshake, InstrCount increments.
  - Operator==2'b11: go to BRANCH.
  - Otherwise PC <= PC+1, then the next state is FETCH if input_Enable=1, else IDLE.
- BRANCH:
  - output_InstrValid=0; wait for input_BranchDone.
  - Taken: PC <= PC+1+output_Imm. Not taken: PC <= PC+1. Both modulo 2^PC_WIDTH.
  - Next state chosen by input_Enable, as in ISSUE.
  - input_BranchDone in any other state is ignored.
- FAULT: output_Fault=1, all other control outputs 0, PC frozen; leaves only on reset.
- Deasserting Enable mid-instruction does not abort it; the instruction completes, and no new fetch starts.
- Latency: input_Enable seen in IDLE on cycle N gives MemReq on N+1; MemValid on N+2 gives InstrValid on N+3.
- Back-to-back non-branch instructions with 1-cycle memory and ready held high take 3 cycles per instruction.
- Reset asserted mid-operation aborts immediately; a pending memory response after reset release is ignored because the FSM is in IDLE.

Test Plan:
- Reset mid-ISSUE (PC=5, InstrValid=1) -> all outputs 0 asynchronously; after release, state IDLE and PC=0.
- Enable=1, 1-cycle memory, ROM[0]=8'b00_01_10_11, ready held high -> MemReq at cycle 1 with addr 0, then InstrValid at cycle 3 with Operator=0, Rs=1, Rt=2, Rd=3, Imm=8'hFF, PC=0. Next MemAddr=1 and InstrCount=1.
- Hold InstrReady=0 for 5 cycles while presenting ROM[2]=8'h6A -> fields and InstrValid stable; single increment of InstrCount on accept.
- Branch 8'b11_00_00_10 (Imm=-2) at PC=4:
  - BranchDone with Taken=1 -> next MemAddr=3.
  - Repeat with Taken=0 -> next MemAddr=5.
  - At PC=255 with Imm=+1, taken -> MemAddr=1 (wrap).
- MemValid withheld, MAX_WAIT=4 -> Fault=1 after 3 WAIT cycles, stays 1 for 20 cycles, MemReq never reasserts.
- Same setup but MemValid on the 3rd WAIT cycle -> no fault, normal issue.
- Enable dropped during WAIT -> the instruction still issues; after accept, state is IDLE and no MemReq follows.
